// File: rtl/seqdet_stream_pkg.sv
// Shared types and default sizing for the streaming sequence detector.
package seqdet_stream_pkg;

    localparam int DEF_WORD_W = 8;
    localparam int DEF_PAT_W  = 4;
    localparam int DEF_CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

endpackage

// File: rtl/seqdet_pat_core.sv
// Bit-serial pattern matcher. It keeps the last PAT_W bits and a fill level,
// so a match is only reported once a full window of fresh history exists.
// In non-overlap mode the history restarts after each hit.
module seqdet_pat_core #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             bit_in,
    input  logic             clear,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             hit
);

    localparam int FW = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d, fill_inc;

    // Next history window and hit decision for the bit being presented.
    always_comb begin
        hist_d   = {hist_q[PAT_W-2:0], bit_in};
        fill_inc = (fill_q == FW'(PAT_W)) ? fill_q : fill_q + 1'b1;
        hit      = en && (fill_inc == FW'(PAT_W)) && (hist_d == pattern);
        fill_d   = (hit && !overlap) ? '0 : fill_inc;
    end

    // History registers; clear wipes them regardless of en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (clear) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (en) begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seqdet_stream_ctrl.sv
// Word-to-bit streaming controller: accepts a word, shifts it MSB-first into
// the pattern core, counts hits (saturating) and reports the count.
// History lives in the core and spans words; the count is per word.
module seqdet_stream_ctrl
    import seqdet_stream_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int PAT_W  = DEF_PAT_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic [PAT_W-1:0]  pattern,
    input  logic              overlap,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_hit,
    output logic              busy
);

    localparam int IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    state_e            state_q;
    logic [WORD_W-1:0] shreg_q;
    logic [IW-1:0]     idx_q;
    logic [PAT_W-1:0]  pat_q;
    logic              ovl_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_valid_q;
    logic              out_hit_q;
    logic              core_en;
    logic              core_hit;

    assign core_en   = (state_q == ST_SHIFT);
    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_count = cnt_q;
    assign out_hit   = out_hit_q;

    seqdet_pat_core #(.PAT_W(PAT_W)) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (core_en),
        .bit_in  (shreg_q[idx_q]),
        .clear   (clear),
        .pattern (pat_q),
        .overlap (ovl_q),
        .hit     (core_hit)
    );

    // Saturating hit count: sticks at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (core_hit && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    // Sequencing FSM with registered result outputs; clear overrides all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            idx_q       <= '0;
            pat_q       <= '0;
            ovl_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_hit_q   <= 1'b0;
        end else if (clear) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_hit_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        shreg_q   <= in_data;
                        pat_q     <= pattern;
                        ovl_q     <= overlap;
                        cnt_q     <= '0;
                        out_hit_q <= 1'b0;
                        idx_q     <= IW'(WORD_W - 1);
                        state_q   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    cnt_q     <= cnt_d;
                    out_hit_q <= (cnt_d != '0);
                    if (idx_q == '0) begin
                        state_q     <= ST_REPORT;
                        out_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seqdet_stream_ctrl.sv
// Bench for seqdet_stream_ctrl: two instances (4-bit and 2-bit counters)
// driven in lockstep, checked every cycle against a queue-based bit-stream
// model, plus directed words with hand-computed counts and latency.
module tb_seqdet_stream_ctrl;

    localparam int WORD_W = 8;
    localparam int PAT_W  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       clear = 1'b0;
    logic       overlap = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_data = '0;
    logic [3:0] pattern = '0;

    logic       in_ready_a, busy_a, out_valid_a, out_hit_a;
    logic [3:0] out_count_a;
    logic       in_ready_b, busy_b, out_valid_b, out_hit_b;
    logic [1:0] out_count_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seqdet_stream_ctrl #(.WORD_W(8), .PAT_W(4), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .pattern(pattern), .overlap(overlap), .clear(clear),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_count(out_count_a),
        .out_hit(out_hit_a), .busy(busy_a)
    );

    seqdet_stream_ctrl #(.WORD_W(8), .PAT_W(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .pattern(pattern), .overlap(overlap), .clear(clear),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_count(out_count_b),
        .out_hit(out_hit_b), .busy(busy_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase: 0 idle, 1 shifting, 2 reporting. The bit stream since the last
    // restart is kept as a queue; a hit is the newest PAT_W bits equal to
    // the latched pattern.
    int         m_ph = 0;
    int         m_left = 0;
    int         m_raw = 0;
    logic [7:0] m_word = '0;
    logic [3:0] m_pat = '0;
    logic       m_ovl = 1'b0;
    bit         q[$];

    function automatic bit q_matches();
        for (int i = 0; i < PAT_W; i++)
            if (q[i] != m_pat[PAT_W-1-i]) return 1'b0;
        return 1'b1;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_ph = 0; m_left = 0; m_raw = 0; q.delete();
        end else if (clear) begin
            m_ph = 0; m_raw = 0; q.delete();
        end else begin
            case (m_ph)
                0: if (in_valid) begin
                    m_word = in_data; m_pat = pattern; m_ovl = overlap;
                    m_raw = 0; m_left = WORD_W; m_ph = 1;
                end
                1: begin
                    q.push_back(m_word[m_left-1]);
                    if (q.size() > PAT_W) void'(q.pop_front());
                    if (q.size() == PAT_W && q_matches()) begin
                        m_raw++;
                        if (!m_ovl) q.delete();
                    end
                    m_left--;
                    if (m_left == 0) m_ph = 2;
                end
                default: if (out_ready) m_ph = 0;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_valid", out_valid_a, 0);
                chk("rst_ready", in_ready_a, 1);
                chk("rst_count", out_count_a, 0);
            end else begin
                chk("m_ready_a", in_ready_a, m_ph == 0);
                chk("m_busy_a",  busy_a,     m_ph != 0);
                chk("m_valid_a", out_valid_a, m_ph == 2);
                chk("m_ready_b", in_ready_b, m_ph == 0);
                chk("m_valid_b", out_valid_b, m_ph == 2);
                if (m_ph == 2) begin
                    chk("m_count_a", out_count_a, (m_raw > 15) ? 15 : m_raw);
                    chk("m_hit_a",   out_hit_a,   m_raw != 0);
                    chk("m_count_b", out_count_b, (m_raw > 3) ? 3 : m_raw);
                    chk("m_hit_b",   out_hit_b,   m_raw != 0);
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    // Called and returning at a negedge. Offers a word, scrambles the
    // config inputs afterwards, checks latency (out_valid seen high by edge
    // T+WORD_W+1), the literal counts, backpressure stability and release.
    task automatic do_word(input logic [7:0] d, input logic [3:0] p, input logic o,
                           input int hold, input int exp_a, input int exp_b,
                           input string nm);
        int k;
        logic [3:0] held;
        chk({nm, "_rdy"}, in_ready_a, 1);
        in_valid = 1'b1; in_data = d; pattern = p; overlap = o; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_data = 8'($urandom); pattern = 4'($urandom); overlap = 1'($urandom);
        k = 0;
        while (!out_valid_a && k < 20) begin
            @(posedge clk); @(negedge clk); k++;
        end
        chk({nm, "_lat"}, k, WORD_W);
        chk({nm, "_cnt_a"}, out_count_a, exp_a);
        chk({nm, "_cnt_b"}, out_count_b, exp_b);
        chk({nm, "_hit"}, out_hit_a, exp_a != 0);
        held = out_count_a;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            chk({nm, "_bp_valid"}, out_valid_a, 1);
            chk({nm, "_bp_cnt"}, out_count_a, held);
            chk({nm, "_bp_ready"}, in_ready_a, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        chk({nm, "_release"}, in_ready_a, 1);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1010_1010 non-overlap: hits at bits 4 and 8; with 5-cycle backpressure.
        do_word(8'hAA, 4'hA, 1'b0, 5, 2, 2, "nonovl");
        pulse_reset();
        // Same word overlapping: hits at bits 4, 6, 8.
        do_word(8'hAA, 4'hA, 1'b1, 0, 3, 3, "ovl");
        // Cross-word: 0101 tail + leading 0 of next word completes 1010.
        pulse_clear();
        do_word(8'h05, 4'hA, 1'b0, 0, 0, 0, "xw1");
        do_word(8'h00, 4'hA, 1'b0, 0, 1, 1, "xw2");
        // Saturation: eight 1s with 1111 overlapping gives 5 raw hits.
        pulse_reset();
        do_word(8'hFF, 4'hF, 1'b1, 0, 5, 3, "sat");

        // Abort with clear in the 4th shift cycle; no result may appear.
        in_valid = 1'b1; in_data = 8'hAA; pattern = 4'hA; overlap = 1'b0;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        pulse_clear();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_nv", out_valid_a, 0);
        end
        do_word(8'h0A, 4'hA, 1'b0, 0, 1, 1, "abort_next");

        // Asynchronous reset mid-shift.
        in_valid = 1'b1; in_data = 8'hFF; pattern = 4'hF; overlap = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", in_ready_a, 1);
        chk("arst_busy",  busy_a, 0);
        chk("arst_valid", out_valid_a, 0);
        chk("arst_count", out_count_a, 0);
        chk("arst_hit",   out_hit_a, 0);
        chk("arst_valid_b", out_valid_b, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic with backpressure and occasional clear.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            in_valid  = 1'($urandom);
            in_data   = 8'($urandom);
            pattern   = 4'($urandom);
            overlap   = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 39) == 0);
        end
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
